// File: rtl/mtr_seq_if.sv
// Command, safety and speed signals between the motion sequencer and its host/driver.
interface mtr_seq_if;
  logic        cmd_vld;
  logic [11:0] lft_cmd;
  logic [11:0] rght_cmd;
  logic        cmd_rdy;
  logic        estop;
  logic        OVR_I_shtdwn;
  logic        clr_flt;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        moving;
  logic        at_target;
  logic        fault;

  modport master (
    output cmd_vld, lft_cmd, rght_cmd, estop, OVR_I_shtdwn, clr_flt,
    input  cmd_rdy, lft_spd, rght_spd, moving, at_target, fault
  );

  modport slave (
    input  cmd_vld, lft_cmd, rght_cmd, estop, OVR_I_shtdwn, clr_flt,
    output cmd_rdy, lft_spd, rght_spd, moving, at_target, fault
  );
endinterface

// File: rtl/mtr_seq_ctrl.sv
// Two-sided motor speed sequencer: slew-limited ramping toward commanded targets,
// with emergency stop ramp-down and immediate overcurrent fault shutdown.
module mtr_seq_ctrl #(
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned TICK_DIV  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  mtr_seq_if.slave    bus
);

  localparam int unsigned SPD_W = 12;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SPD_W-1:0] STEP_U    = SPD_W'(RAMP_STEP);
  localparam logic signed [SPD_W:0] STEP_S = (SPD_W+1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_STOP  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SPD_W-1:0] lft_tgt_q, lft_tgt_d, rght_tgt_q, rght_tgt_d;
  logic [SPD_W-1:0] lft_spd_q, lft_spd_d, rght_spd_q, rght_spd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             moving_q, moving_d;
  logic             at_target_q, at_target_d;
  logic             fault_q, fault_d;

  logic             tick;
  logic [SPD_W-1:0] lft_cmd_cl, rght_cmd_cl;
  logic [SPD_W-1:0] lft_slew, rght_slew;

  // One slew step toward tgt; the 13-bit difference cannot overflow.
  function automatic logic [SPD_W-1:0] slew_step(input logic [SPD_W-1:0] tgt,
                                                 input logic [SPD_W-1:0] spd);
    logic signed [SPD_W:0] diff;
    diff = $signed({tgt[SPD_W-1], tgt}) - $signed({spd[SPD_W-1], spd});
    if (diff > STEP_S)       slew_step = spd + STEP_U;
    else if (diff < -STEP_S) slew_step = spd - STEP_U;
    else                     slew_step = tgt;
  endfunction

  always_comb begin
    state_d     = state_q;
    lft_tgt_d   = lft_tgt_q;
    rght_tgt_d  = rght_tgt_q;
    lft_spd_d   = lft_spd_q;
    rght_spd_d  = rght_spd_q;

    tick        = (cnt_q == TICK_LAST);
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    // -2048 has no positive mirror, so it is pulled in by one LSB
    lft_cmd_cl  = (bus.lft_cmd  == 12'h800) ? 12'h801 : bus.lft_cmd;
    rght_cmd_cl = (bus.rght_cmd == 12'h800) ? 12'h801 : bus.rght_cmd;
    lft_slew    = tick ? slew_step(lft_tgt_q,  lft_spd_q)  : lft_spd_q;
    rght_slew   = tick ? slew_step(rght_tgt_q, rght_spd_q) : rght_spd_q;

    if (bus.OVR_I_shtdwn) begin
      state_d    = S_FAULT;
      lft_tgt_d  = '0;
      rght_tgt_d = '0;
      lft_spd_d  = '0;
      rght_spd_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          lft_spd_d  = '0;
          rght_spd_d = '0;
          if (bus.estop) begin
            lft_tgt_d  = '0;
            rght_tgt_d = '0;
            state_d    = S_STOP;
          end else if (bus.cmd_vld) begin
            lft_tgt_d  = lft_cmd_cl;
            rght_tgt_d = rght_cmd_cl;
            if ((lft_cmd_cl != '0) || (rght_cmd_cl != '0)) state_d = S_RAMP;
          end
        end
        S_RAMP: begin
          lft_spd_d  = lft_slew;
          rght_spd_d = rght_slew;
          if (bus.estop) begin
            lft_tgt_d  = '0;
            rght_tgt_d = '0;
            state_d    = S_STOP;
          end else begin
            if (bus.cmd_vld) begin
              lft_tgt_d  = lft_cmd_cl;
              rght_tgt_d = rght_cmd_cl;
            end
            if ((lft_tgt_d == '0) && (rght_tgt_d == '0) &&
                (lft_spd_d == '0) && (rght_spd_d == '0)) state_d = S_IDLE;
          end
        end
        S_STOP: begin
          lft_tgt_d  = '0;
          rght_tgt_d = '0;
          lft_spd_d  = lft_slew;
          rght_spd_d = rght_slew;
          if ((lft_spd_q == '0) && (rght_spd_q == '0) && !bus.estop) state_d = S_IDLE;
        end
        S_FAULT: begin
          lft_tgt_d  = '0;
          rght_tgt_d = '0;
          lft_spd_d  = '0;
          rght_spd_d = '0;
          if (bus.clr_flt) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    cmd_rdy_d   = (state_d == S_IDLE) || (state_d == S_RAMP);
    moving_d    = (lft_spd_d != '0) || (rght_spd_d != '0);
    at_target_d = (state_d == S_RAMP) && (lft_spd_d == lft_tgt_d) && (rght_spd_d == rght_tgt_d);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lft_tgt_q   <= '0;
      rght_tgt_q  <= '0;
      lft_spd_q   <= '0;
      rght_spd_q  <= '0;
      cmd_rdy_q   <= 1'b1;
      moving_q    <= 1'b0;
      at_target_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lft_tgt_q   <= lft_tgt_d;
      rght_tgt_q  <= rght_tgt_d;
      lft_spd_q   <= lft_spd_d;
      rght_spd_q  <= rght_spd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      moving_q    <= moving_d;
      at_target_q <= at_target_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.lft_spd   = lft_spd_q;
  assign bus.rght_spd  = rght_spd_q;
  assign bus.moving    = moving_q;
  assign bus.at_target = at_target_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_mtr_seq_ctrl.sv
// Scoreboard bench for mtr_seq_ctrl: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them against the DUT one step after every rising edge.
module tb_mtr_seq_ctrl;

  localparam int STEP = 8;
  localparam int TD   = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_STOP  = 2;
  localparam int M_FAULT = 3;

  typedef struct {
    int ls;
    int rs;
    int rdy;
    int mov;
    int at;
    int flt;
  } exp_t;

  logic clk;
  logic rst_n;
  mtr_seq_if bus ();

  mtr_seq_ctrl #(.RAMP_STEP(STEP), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  // model state
  int m_st, m_lt, m_rt, m_ls, m_rs, m_cycles;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slew_m(input int t, input int s);
    if (t - s > STEP)       return s + STEP;
    else if (t - s < -STEP) return s - STEP;
    else                    return t;
  endfunction

  function automatic int clamp_m(input int v);
    return (v == -2048) ? -2047 : v;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_lt = 0; m_rt = 0; m_ls = 0; m_rs = 0; m_cycles = 0;
    sb_q.delete();
  endtask

  // Drive inputs for the coming edge, advance the model and queue its prediction.
  task automatic apply(input bit vld, input int lc, input int rc,
                       input bit es, input bit ov, input bit cf);
    bit   tick;
    exp_t e;
    bus.cmd_vld      = vld;
    bus.lft_cmd      = 12'(lc);
    bus.rght_cmd     = 12'(rc);
    bus.estop        = es;
    bus.OVR_I_shtdwn = ov;
    bus.clr_flt      = cf;

    tick = ((m_cycles % TD) == TD - 1);
    m_cycles++;

    if (ov) begin
      m_st = M_FAULT; m_lt = 0; m_rt = 0; m_ls = 0; m_rs = 0;
    end else if (m_st == M_IDLE) begin
      if (es) m_st = M_STOP;
      else if (vld) begin
        m_lt = clamp_m(lc); m_rt = clamp_m(rc);
        if (m_lt != 0 || m_rt != 0) m_st = M_RAMP;
      end
    end else if (m_st == M_RAMP) begin
      if (tick) begin m_ls = slew_m(m_lt, m_ls); m_rs = slew_m(m_rt, m_rs); end
      if (es) begin
        m_lt = 0; m_rt = 0; m_st = M_STOP;
      end else begin
        if (vld) begin m_lt = clamp_m(lc); m_rt = clamp_m(rc); end
        if (m_lt == 0 && m_rt == 0 && m_ls == 0 && m_rs == 0) m_st = M_IDLE;
      end
    end else if (m_st == M_STOP) begin
      if (m_ls == 0 && m_rs == 0 && !es) m_st = M_IDLE;
      if (tick) begin m_ls = slew_m(0, m_ls); m_rs = slew_m(0, m_rs); end
    end else begin
      if (cf) m_st = M_IDLE;
    end

    e.ls  = m_ls;
    e.rs  = m_rs;
    e.rdy = (m_st == M_IDLE || m_st == M_RAMP) ? 1 : 0;
    e.mov = (m_ls != 0 || m_rs != 0) ? 1 : 0;
    e.at  = (m_st == M_RAMP && m_ls == m_lt && m_rs == m_rt) ? 1 : 0;
    e.flt = (m_st == M_FAULT) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit vld, input int lc, input int rc,
                       input bit es, input bit ov, input bit cf);
    @(negedge clk);
    apply(vld, lc, rc, es, ov, cf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_lft_spd"},   int'($signed(bus.lft_spd)),  0);
    chk({tag, "_rght_spd"},  int'($signed(bus.rght_spd)), 0);
    chk({tag, "_cmd_rdy"},   int'(bus.cmd_rdy),   1);
    chk({tag, "_moving"},    int'(bus.moving),    0);
    chk({tag, "_at_target"}, int'(bus.at_target), 0);
    chk({tag, "_fault"},     int'(bus.fault),     0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every post-edge output set against the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no prediction expected one at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk("lft_spd",   int'($signed(bus.lft_spd)),  e.ls);
        chk("rght_spd",  int'($signed(bus.rght_spd)), e.rs);
        chk("cmd_rdy",   int'(bus.cmd_rdy),   e.rdy);
        chk("moving",    int'(bus.moving),    e.mov);
        chk("at_target", int'(bus.at_target), e.at);
        chk("fault",     int'(bus.fault),     e.flt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int es_left;
    rst_n = 1'b0;
    bus.cmd_vld = 0; bus.lft_cmd = '0; bus.rght_cmd = '0;
    bus.estop = 0; bus.OVR_I_shtdwn = 0; bus.clr_flt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    idle(6);

    // symmetric ramp to +20/-20
    drive(1, 20, -20, 0, 0, 0);
    idle(16);

    // estop from a mid-ramp speed of 16, held then released
    do_reset("rst_a");
    drive(1, 20, -20, 0, 0, 0);
    for (int i = 0; i < 20 && m_ls != 16; i++) drive(0, 0, 0, 0, 0, 0);
    chk("reach_16", m_ls, 16);
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 0, 0);
    idle(3);

    // overcurrent at speed 100, clear ignored while shutdown persists
    drive(1, 100, 100, 0, 0, 0);
    for (int i = 0; i < 100 && m_ls != 100; i++) drive(0, 0, 0, 0, 0, 0);
    chk("reach_100", m_ls, 100);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    idle(2);
    drive(0, 0, 0, 0, 0, 1);
    idle(3);

    // clamp of -2048, then reversal -40 -> +40
    drive(1, -2048, 0, 0, 0, 0);
    idle(1040);
    chk("clamp_tgt", m_ls, -2047);
    drive(1, -40, 0, 0, 0, 0);
    idle(1010);
    drive(1, 40, 0, 0, 0, 0);
    idle(44);

    // command coincident with estop is discarded
    do_reset("rst_b");
    drive(1, 50, 50, 1, 0, 0);
    idle(3);

    // reset mid-ramp
    drive(1, 200, -200, 0, 0, 0);
    idle(20);
    do_reset("rst_c");
    idle(10);

    // randomized traffic
    es_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit vld, es, ov, cf;
      int lc, rc;
      vld = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0) begin
        lc = int'($urandom_range(0, 4095)) - 2048;
        rc = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        lc = int'($urandom_range(0, 80)) - 40;
        rc = int'($urandom_range(0, 80)) - 40;
      end
      if (es_left == 0 && $urandom_range(0, 59) == 0) es_left = int'($urandom_range(1, 20));
      es = (es_left > 0);
      if (es_left > 0) es_left--;
      ov = ($urandom_range(0, 199) == 0);
      cf = ($urandom_range(0, 7) == 0);
      drive(vld, lc, rc, es, ov, cf);
    end
    idle(4);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
